// File: rtl/line_bank_controller.sv
// line_bank_controller
// Captures ADC lines into a ring of line banks held in an external RAM and replays
// them with horizontal rescaling (fixed-point step) and vertical line repetition.
// Optional build macro: LBC_STATUS_EN adds 8-bit saturating overflow/underflow
// event counters; without it ovf_count/unf_count are tied to zero.
module line_bank_controller #(
  parameter int PIXEL_W     = 12,
  parameter int BANK_BITS   = 2,
  parameter int LINE_BITS   = 10,
  parameter int FRAC_BITS   = 8,
  parameter int PRIME_LINES = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sample_enable,
  input  logic                           h_sync_in,
  input  logic                           active_video_in,
  input  logic [PIXEL_W-1:0]             pixel_data_in,
  input  logic                           line_reset,
  input  logic                           hdmi_request,
  input  logic [LINE_BITS+FRAC_BITS-1:0] h_step,
  input  logic [3:0]                     line_repeat,
  output logic [PIXEL_W-1:0]             pixel_data_out,
  output logic                           ram_wr_en,
  output logic [BANK_BITS+LINE_BITS-1:0] ram_wr_addr,
  output logic [PIXEL_W-1:0]             ram_wr_data,
  output logic [BANK_BITS+LINE_BITS-1:0] ram_rd_addr,
  input  logic [PIXEL_W-1:0]             ram_rd_data,
  output logic [BANK_BITS:0]             fill_level,
  output logic                           overflow,
  output logic                           underflow,
  output logic [7:0]                     ovf_count,
  output logic [7:0]                     unf_count
);

  localparam int BANKS = 1 << BANK_BITS;
  localparam int ACC_W = LINE_BITS + FRAC_BITS;
  localparam int LEN_W = LINE_BITS + 1;   // a full line holds 2**LINE_BITS words
  localparam logic [BANK_BITS:0]   BANKS_FILL = (BANK_BITS+1)'(BANKS);
  localparam logic [BANK_BITS:0]   PRIME_FILL = (BANK_BITS+1)'(PRIME_LINES);
  localparam logic [BANK_BITS:0]   ONE_FILL   = (BANK_BITS+1)'(1);
  localparam logic [LEN_W-1:0]     FULL_LEN   = LEN_W'(1 << LINE_BITS);
  localparam logic [LINE_BITS-1:0] OFF_MAX    = '1;

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t               state_q, state_d;
  logic [BANK_BITS-1:0] w_bank_q, r_bank_q;
  logic [LINE_BITS-1:0] w_off_q;
  logic                 w_sat_q;          // last word of the line already written
  logic [LEN_W-1:0]     len_q [BANKS];
  logic [BANK_BITS:0]   fill_q;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [3:0]           rep_q;
  logic                 req_d1_q;
  logic [PIXEL_W-1:0]   pix_q;
  logic                 ovf_q, unf_q;

  logic                 wr_go, commit, commit_adv, ovf_evt;
  logic                 line_end, rel_line, unf_evt, start_run;
  logic [LEN_W-1:0]     w_count, rd_len, rd_last;
  logic [3:0]           rep_lim, rep_inc;
  logic [LINE_BITS-1:0] acc_int, rd_off;
  logic [ACC_W:0]       acc_sum;

  // Write side: a saturated line stops writing but still commits its full length.
  assign wr_go      = active_video_in & sample_enable & ~w_sat_q;
  assign w_count    = w_sat_q ? FULL_LEN : {1'b0, w_off_q};
  assign commit     = h_sync_in & (w_sat_q | (w_off_q != '0));
  assign commit_adv = commit & (fill_q < BANKS_FILL);
  assign ovf_evt    = commit & ~commit_adv;

  // Read side: a line ends after max(line_repeat,1) output lines; the last
  // committed line is never released, it is replayed instead.
  assign rep_lim  = (line_repeat == 4'd0) ? 4'd1 : line_repeat;
  assign rep_inc  = rep_q + 4'd1;
  assign line_end = (state_q == RUN) & line_reset & (rep_inc >= rep_lim);
  assign rel_line = line_end & ((fill_q > ONE_FILL) | commit_adv);
  assign unf_evt  = line_end & ~rel_line;
  assign start_run = (state_q == PRIME) & (state_d == RUN);

  // Read address clamps to the last stored word of the current bank.
  assign acc_int = acc_q[ACC_W-1:FRAC_BITS];
  assign rd_len  = len_q[r_bank_q];
  assign rd_last = (rd_len == '0) ? '0 : rd_len - LEN_W'(1);
  assign rd_off  = ({1'b0, acc_int} > rd_last) ? rd_last[LINE_BITS-1:0] : acc_int;
  assign acc_sum = {1'b0, acc_q} + {1'b0, h_step};

  // Horizontal accumulator next value: cleared per output line, saturating add.
  always_comb begin
    acc_d = acc_q;
    if (line_reset) begin
      acc_d = '0;
    end else if (hdmi_request) begin
      acc_d = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
    end
  end

  // Read FSM next state: wait for data, then for enough buffered lines.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (commit) state_d = PRIME;
      PRIME:   if (line_reset && (fill_q >= PRIME_FILL)) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Write pointer, saturation and per-bank committed lengths.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_bank_q <= '0;
      w_off_q  <= '0;
      w_sat_q  <= 1'b0;
      for (int i = 0; i < BANKS; i++) len_q[i] <= '0;
    end else if (h_sync_in) begin
      w_off_q <= '0;
      w_sat_q <= 1'b0;
      if (commit)     len_q[w_bank_q] <= w_count;
      if (commit_adv) w_bank_q <= w_bank_q + BANK_BITS'(1);
    end else if (wr_go) begin
      if (w_off_q == OFF_MAX) w_sat_q <= 1'b1;
      else                    w_off_q <= w_off_q + LINE_BITS'(1);
    end
  end

  // Fill level: a commit and a release in the same cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           fill_q <= '0;
    else if (commit_adv && !rel_line)  fill_q <= fill_q + ONE_FILL;
    else if (rel_line && !commit_adv)  fill_q <= fill_q - ONE_FILL;
  end

  // Read bank, accumulator and line-repeat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bank_q <= '0;
      acc_q    <= '0;
      rep_q    <= '0;
    end else begin
      acc_q <= acc_d;
      if (start_run) begin
        rep_q <= '0;
      end else if ((state_q == RUN) && line_reset) begin
        if (line_end) begin
          rep_q <= '0;
          if (rel_line) r_bank_q <= r_bank_q + BANK_BITS'(1);
        end else begin
          rep_q <= rep_inc;
        end
      end
    end
  end

  // Sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | ovf_evt;
      unf_q <= unf_q | unf_evt;
    end
  end

  // Output pipeline: one stage aligns the request with the RAM read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_d1_q <= 1'b0;
      pix_q    <= '0;
    end else begin
      req_d1_q <= hdmi_request;
      pix_q    <= (req_d1_q && (state_q == RUN)) ? ram_rd_data : '0;
    end
  end

`ifdef LBC_STATUS_EN
  logic [7:0] ovf_cnt_q, unf_cnt_q;

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt_q <= '0;
      unf_cnt_q <= '0;
    end else begin
      if (ovf_evt && (ovf_cnt_q != 8'hFF)) ovf_cnt_q <= ovf_cnt_q + 8'd1;
      if (unf_evt && (unf_cnt_q != 8'hFF)) unf_cnt_q <= unf_cnt_q + 8'd1;
    end
  end

  assign ovf_count = ovf_cnt_q;
  assign unf_count = unf_cnt_q;
`else
  assign ovf_count = 8'd0;
  assign unf_count = 8'd0;
`endif

  assign ram_wr_en      = wr_go;
  assign ram_wr_addr    = {w_bank_q, w_off_q};
  assign ram_wr_data    = pixel_data_in;
  assign ram_rd_addr    = {r_bank_q, rd_off};
  assign pixel_data_out = pix_q;
  assign fill_level     = fill_q;
  assign overflow       = ovf_q;
  assign underflow      = unf_q;

endmodule

// File: tb/tb_line_bank_controller.sv
// Directed testbench for line_bank_controller with a cycle-level behavioural model
// (line-count bookkeeping, scaled read positions, expected pixel stream) checked on
// every negative clock edge, plus hand-computed literal expectations.
module tb_line_bank_controller;
  localparam int PW = 12, BB = 2, LB = 10, FB = 8, PL = 2;
  localparam int BANKS = 4, WORDS = 1024, ACC_MAX = (1 << 18) - 1;
  localparam int PH_IDLE = 0, PH_PRIME = 1, PH_RUN = 2;
`ifdef LBC_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_enable = 1'b0, h_sync_in = 1'b0, active_video_in = 1'b0;
  logic [PW-1:0] pixel_data_in = '0;
  logic          line_reset = 1'b0, hdmi_request = 1'b0;
  logic [17:0]   h_step = 18'h100;
  logic [3:0]    line_repeat = 4'd1;
  logic [PW-1:0] pixel_data_out, ram_wr_data, ram_rd_data;
  logic          ram_wr_en, overflow, underflow;
  logic [11:0]   ram_wr_addr, ram_rd_addr;
  logic [2:0]    fill_level;
  logic [7:0]    ovf_count, unf_count;

  line_bank_controller #(.PIXEL_W(PW), .BANK_BITS(BB), .LINE_BITS(LB),
                         .FRAC_BITS(FB), .PRIME_LINES(PL)) dut (
    .clk(clk), .rst(rst), .sample_enable(sample_enable), .h_sync_in(h_sync_in),
    .active_video_in(active_video_in), .pixel_data_in(pixel_data_in),
    .line_reset(line_reset), .hdmi_request(hdmi_request), .h_step(h_step),
    .line_repeat(line_repeat), .pixel_data_out(pixel_data_out),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data), .fill_level(fill_level),
    .overflow(overflow), .underflow(underflow), .ovf_count(ovf_count),
    .unf_count(unf_count));

  always #5 clk = ~clk;

  // External line RAM: registered read, read-before-write.
  logic [PW-1:0] ram [BANKS*WORDS];
  initial for (int i = 0; i < BANKS*WORDS; i++) ram[i] = '0;
  always @(posedge clk) begin
    if (ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= ram[ram_rd_addr];
  end

  int n_checks = 0, n_fail = 0;
  int cap[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_wbank, m_woff, m_rbank, m_acc, m_rep, m_fill, m_phase, m_ovfc, m_unfc;
  int m_pix, m_rd;
  bit m_wsat, m_ovf, m_unf, m_req1, m_pix_valid;
  int m_len [BANKS];
  int m_mem [BANKS*WORDS];
  initial for (int i = 0; i < BANKS*WORDS; i++) m_mem[i] = 0;

  task automatic model_reset();
    m_wbank = 0; m_woff = 0; m_wsat = 0; m_rbank = 0; m_acc = 0; m_rep = 0;
    m_fill = 0; m_phase = PH_IDLE; m_ovf = 0; m_unf = 0; m_ovfc = 0; m_unfc = 0;
    m_pix = 0; m_pix_valid = 0; m_req1 = 0; m_rd = 0;
    for (int i = 0; i < BANKS; i++) m_len[i] = 0;
  endtask

  function automatic int exp_rd_addr();
    int top, off;
    top = (m_len[m_rbank] == 0) ? 0 : m_len[m_rbank] - 1;
    off = m_acc >> FB;
    if (off > top) off = top;
    return m_rbank * WORDS + off;
  endfunction

  task automatic model_compare();
    bit wr;
    wr = active_video_in && sample_enable && !m_wsat;
    check("pixel_data_out", pixel_data_out, m_pix);
    if (m_pix_valid) cap.push_back(int'(pixel_data_out));
    check("fill_level", fill_level, m_fill);
    check("overflow", overflow, m_ovf);
    check("underflow", underflow, m_unf);
    check("ovf_count", ovf_count, m_ovfc);
    check("unf_count", unf_count, m_unfc);
    check("ram_wr_en", ram_wr_en, wr);
    if (wr) check("ram_wr_addr", ram_wr_addr, m_wbank * WORDS + m_woff);
    check("ram_wr_data", ram_wr_data, pixel_data_in);
    if (m_phase == PH_RUN) check("ram_rd_addr", ram_rd_addr, exp_rd_addr());
  endtask

  task automatic model_step();
    int wcount, lim, old_phase, rd_a, sum;
    bit wr, commit, adds, rel;
    wr        = active_video_in && sample_enable && !m_wsat;
    wcount    = m_wsat ? WORDS : m_woff;
    commit    = h_sync_in && (wcount > 0);
    adds      = commit && (m_fill < BANKS);
    lim       = (line_repeat == 0) ? 1 : int'(line_repeat);
    rd_a      = exp_rd_addr();
    old_phase = m_phase;
    rel       = 0;
    // output stream: RAM data of the previous cycle's address, only while running
    m_pix_valid = m_req1 && (old_phase == PH_RUN);
    m_pix  = m_pix_valid ? m_rd : 0;
    m_rd   = m_mem[rd_a];
    m_req1 = hdmi_request;
    if (wr) m_mem[m_wbank * WORDS + m_woff] = int'(pixel_data_in);
    // line capture
    if (h_sync_in) begin
      if (commit) begin
        m_len[m_wbank] = wcount;
        if (adds) m_wbank = (m_wbank + 1) % BANKS;
        else begin
          m_ovf = 1;
          if (STATUS_EN && m_ovfc < 255) m_ovfc++;
        end
      end
      m_woff = 0; m_wsat = 0;
    end else if (wr) begin
      if (m_woff == WORDS - 1) m_wsat = 1;
      else m_woff++;
    end
    // horizontal position
    if (line_reset) m_acc = 0;
    else if (hdmi_request) begin
      sum = m_acc + int'(h_step);
      m_acc = (sum > ACC_MAX) ? ACC_MAX : sum;
    end
    // output line sequencing
    if (line_reset && old_phase == PH_RUN) begin
      if (m_rep + 1 >= lim) begin
        m_rep = 0;
        if (m_fill > 1 || adds) begin
          rel = 1;
          m_rbank = (m_rbank + 1) % BANKS;
        end else begin
          m_unf = 1;
          if (STATUS_EN && m_unfc < 255) m_unfc++;
        end
      end else m_rep++;
    end
    if (old_phase == PH_IDLE && commit) m_phase = PH_PRIME;
    if (old_phase == PH_PRIME && line_reset && m_fill >= PL) begin
      m_phase = PH_RUN;
      m_rep = 0;
    end
    m_fill = m_fill + int'(adds) - int'(rel);
  endtask

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (rst) model_reset();
    model_compare();
    if (!rst) model_step();
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_line(input int base, input int n, input bit alt);
    for (int k = 0; k < n; k++) begin
      active_video_in = 1'b1;
      sample_enable   = 1'b1;
      pixel_data_in   = PW'(base + k);
      tick();
      if (alt) begin
        sample_enable = 1'b0;
        tick();
      end
    end
    active_video_in = 1'b0;
    sample_enable   = 1'b0;
    pixel_data_in   = '0;
    tick();
    h_sync_in = 1'b1;
    tick();
    h_sync_in = 1'b0;
    tick();
    $display("[%0t] line base=0x%0h n=%0d committed, fill=%0d", $time, base, n, fill_level);
  endtask

  task automatic pulse_lr();
    line_reset = 1'b1;
    tick();
    line_reset = 1'b0;
    tick();
    $display("[%0t] line_reset, fill=%0d rd_addr=0x%0h", $time, fill_level, ram_rd_addr);
  endtask

  task automatic run_req(input int n);
    cap.delete();
    hdmi_request = 1'b1;
    repeat (n) tick();
    hdmi_request = 1'b0;
    repeat (3) tick();
    $display("[%0t] %0d requests, h_step=0x%0h, %0d pixels captured", $time, n, h_step, cap.size());
  endtask

  function automatic logic [31:0] cap_at(input int idx);
    return (idx < cap.size()) ? 32'(cap[idx]) : 32'hFFFF_FFFF;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    repeat (3) tick();
    check("lit_reset_pix", pixel_data_out, 0);
    check("lit_reset_fill", fill_level, 0);
    check("lit_reset_flags", {overflow, underflow}, 0);
    rst = 1'b0;
    tick();

    // Line 0: 100 samples -> one committed line, readout still held back.
    write_line(12'h100, 100, 1'b0);
    check("lit_fill_first", fill_level, 1);
    // Line 1: sample strobe every other cycle.
    write_line(12'h200, 100, 1'b1);
    check("lit_fill_second", fill_level, 2);

    // 1:1 readout of line 0, then hold on its last sample.
    h_step = 18'h100; line_repeat = 4'd1;
    pulse_lr();
    run_req(1280);
    check("lit_1to1_first", cap_at(0), 12'h100);
    check("lit_1to1_mid", cap_at(50), 12'h132);
    check("lit_1to1_last", cap_at(99), 12'h163);
    check("lit_1to1_hold", cap_at(1279), 12'h163);

    // Half step: each word of line 1 appears twice.
    h_step = 18'h080;
    pulse_lr();
    check("lit_release_fill", fill_level, 1);
    run_req(20);
    check("lit_half_0", cap_at(0), 12'h200);
    check("lit_half_1", cap_at(1), 12'h200);
    check("lit_half_2", cap_at(2), 12'h201);
    check("lit_half_19", cap_at(19), 12'h209);

    // Two more lines, then line_repeat=2.
    write_line(12'h300, 50, 1'b0);
    write_line(12'h400, 50, 1'b0);
    check("lit_fill_four", fill_level, 3);
    line_repeat = 4'd2; h_step = 18'h100;
    pulse_lr();
    check("lit_rep_hold_fill", fill_level, 3);
    check("lit_rep_hold_bank", ram_rd_addr, 12'h400);
    pulse_lr();
    check("lit_rep_adv_fill", fill_level, 2);
    check("lit_rep_adv_bank", ram_rd_addr, 12'h800);
    run_req(3);
    check("lit_rep_data", cap_at(2), 12'h302);

    // Underflow: last line is replayed instead of released.
    line_repeat = 4'd1;
    pulse_lr();
    pulse_lr();
    check("lit_unf_flag", underflow, 1);
    check("lit_unf_fill", fill_level, 1);
    check("lit_unf_bank", ram_rd_addr, 12'hC00);
    check("lit_unf_count", unf_count, STATUS_EN ? 1 : 0);
    run_req(3);
    check("lit_unf_replay", cap_at(0), 12'h400);

    // Reset in the middle of a line while reading.
    hdmi_request = 1'b1;
    for (int k = 0; k < 10; k++) begin
      active_video_in = 1'b1; sample_enable = 1'b1; pixel_data_in = PW'(12'h600 + k);
      tick();
    end
    rst = 1'b1; hdmi_request = 1'b0; active_video_in = 1'b0; sample_enable = 1'b0;
    pixel_data_in = '0;
    #1;
    check("lit_rst_pix", pixel_data_out, 0);
    check("lit_rst_fill", fill_level, 0);
    check("lit_rst_flags", {overflow, underflow}, 0);
    check("lit_rst_addrs", {ram_wr_en, ram_wr_addr, ram_rd_addr}, 0);
    check("lit_rst_counts", {ovf_count, unf_count}, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    h_sync_in = 1'b1; tick(); h_sync_in = 1'b0; tick();
    check("lit_rst_nocommit", fill_level, 0);
    line_reset = 1'b1; tick(); line_reset = 1'b0;
    hdmi_request = 1'b1; repeat (4) tick();
    check("lit_idle_pix", pixel_data_out, 0);
    hdmi_request = 1'b0; tick();
    $display("[%0t] mid-line reset done", $time);

    // Overflow: five commits with no reads.
    for (int i = 0; i < 5; i++) begin
      write_line(12'h500 + 16 * i, 4, 1'b0);
      check("lit_ovf_fill", fill_level, (i < 4) ? i + 1 : 4);
    end
    check("lit_ovf_flag", overflow, 1);
    check("lit_ovf_count", ovf_count, STATUS_EN ? 1 : 0);

    // Write saturation and read-side clamping.
    do_reset();
    write_line(0, 1030, 1'b0);
    check("lit_sat_fill", fill_level, 1);
    write_line(12'h700, 8, 1'b0);
    h_step = 18'h3FFFF;
    pulse_lr();
    run_req(4);
    check("lit_sat_word0", cap_at(0), 12'h000);
    check("lit_sat_last", cap_at(3), 12'h3FF);
    h_step = 18'h0;
    pulse_lr();
    run_req(4);
    check("lit_zero_step", cap_at(3), 12'h700);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end
endmodule
